// File: rtl/macc_shift_ctrl.sv
// Stream controller for a DEPTH-stage shift-register chain: fills from valid/ready input, aligns
// partial fills, drains in arrival order. Define MACC_SHIFT_RECIRC_EN for non-destructive drains.
module macc_shift_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CW    = 11
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             drain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] sr_din,
    output logic [1:0]       sr_sel,
    input  logic [WIDTH-1:0] sr_dout,
`ifdef MACC_SHIFT_RECIRC_EN
    input  logic             recirc,
`endif
    output logic [CW-1:0]    count,
    output logic             busy
);

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_TAIL = 2'b01;

    typedef enum logic [1:0] {
        StFill,
        StAlign,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    pad_q, pad_d;
    logic [CW-1:0]    drained_q, drained_d;
    logic             recirc_q, recirc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic recirc_in;
    logic fill_ready;
    logic accept;
    logic drain_full;
    logic drain_part;
    logic slot_free;
    logic capture;
    logic last_capture;

`ifdef MACC_SHIFT_RECIRC_EN
    assign recirc_in = recirc;
`else
    assign recirc_in = 1'b0;
`endif

    assign fill_ready = (count_q < FULL) && !drain;
    assign accept     = (state_q == StFill) && in_valid && fill_ready;
    assign drain_full = drain && (count_q == FULL);
    assign drain_part = drain && (count_q != '0) && (count_q < FULL);
    assign slot_free  = !out_valid_q || out_ready;
    assign capture    = (state_q == StDrain) && slot_free;

    // A recirculating drain keeps count at FULL, so its end comes from the capture counter.
    assign last_capture = recirc_q ? (drained_q == LAST) : (count_q == ONE);

    // State register.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFill: begin
                if (drain_full) begin
                    state_d = StDrain;
                end else if (drain_part) begin
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (pad_q == ONE) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (capture && last_capture) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Outputs towards the chain and the upstream producer.
    always_comb begin
        in_ready = 1'b0;
        sr_sel   = SEL_HOLD;
        sr_din   = '0;
        busy     = 1'b1;
        case (state_q)
            StFill: begin
                busy     = 1'b0;
                in_ready = fill_ready;
                if (accept) begin
                    sr_sel = SEL_TAIL;
                    sr_din = in_data;
                end
            end
            StAlign: begin
                sr_sel = SEL_TAIL;
            end
            StDrain: begin
                if (capture) begin
                    sr_sel = SEL_TAIL;
                    sr_din = recirc_q ? sr_dout : '0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Counters and output register next state.
    always_comb begin
        count_d     = count_q;
        pad_d       = pad_q;
        drained_d   = drained_q;
        recirc_d    = recirc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            StFill: begin
                if (accept) begin
                    count_d = count_q + ONE;
                end
                if (drain_part) begin
                    pad_d = FULL - count_q;
                end
                // Only a full-chain drain may recirculate; partial drains always zero fill.
                recirc_d  = drain_full && recirc_in;
                drained_d = '0;
            end
            StAlign: begin
                pad_d = pad_q - ONE;
            end
            StDrain: begin
                if (capture) begin
                    drained_d = drained_q + ONE;
                    if (!recirc_q) begin
                        count_d = count_q - ONE;
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = sr_dout;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            count_q     <= '0;
            pad_q       <= '0;
            drained_q   <= '0;
            recirc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            count_q     <= count_d;
            pad_q       <= pad_d;
            drained_q   <= drained_d;
            recirc_q    <= recirc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifndef SYNTHESIS
    count_bound_a: assert property (@(posedge CLK) disable iff (!RST_L) count_q <= FULL);
    no_head_shift_a: assert property (@(posedge CLK) disable iff (!RST_L) sr_sel != 2'b10);
    busy_blocks_in_a: assert property (@(posedge CLK) disable iff (!RST_L) busy |-> !in_ready);
`endif

endmodule
